// File: rtl/doodlejump_soc_debug_cmd_bridge.sv
// System-clock command bridge for the debug slave: synchronised JTAG update strobes feed a show-ahead command FIFO.
// Optional saturating drop counter on ovf_cnt when DBG_BRIDGE_OVF_CNT_EN is defined.
module doodlejump_soc_debug_cmd_bridge #(
    parameter int IR_W        = 2,
    parameter int DATA_W      = 38,
    parameter int ACT_BIT     = 35,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    localparam int NUM_CH     = 2**IR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [DATA_W-1:0] sr,
    input  logic              vs_uir,
    input  logic              vs_udr,
    input  logic              cmd_ready,
    input  logic              ovf_clr,
    output logic              cmd_valid,
    output logic [IR_W-1:0]   cmd_ch,
    output logic [DATA_W-1:0] jdo,
    output logic [NUM_CH-1:0] take_action,
    output logic [NUM_CH-1:0] take_no_action,
    output logic              ovf,
    output logic [7:0]        ovf_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = IR_W + DATA_W;

    logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q;
    logic                   uir_edge_q, udr_edge_q;
    logic                   uir_p, udr_p;
    logic [IR_W-1:0]        ir_q;
    logic [ENT_W-1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q;
    logic                   full, pop, push_ok, drop;
    logic [ENT_W-1:0]       head;

    // Edge flop samples the last sync stage, so a strobe high across reset release reads as a new edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            uir_sync_q <= '0;
            udr_sync_q <= '0;
            uir_edge_q <= 1'b0;
            udr_edge_q <= 1'b0;
        end else begin
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            uir_edge_q <= uir_sync_q[SYNC_STAGES-1];
            udr_edge_q <= udr_sync_q[SYNC_STAGES-1];
        end
    end

    assign uir_p = uir_sync_q[SYNC_STAGES-1] & ~uir_edge_q;
    assign udr_p = udr_sync_q[SYNC_STAGES-1] & ~udr_edge_q;

    always_ff @(posedge clk) begin
        if (!reset_n)   ir_q <= '0;
        else if (uir_p) ir_q <= ir_in;
    end

    assign cmd_valid = (cnt_q != '0);
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign pop       = cmd_valid & cmd_ready;
    assign push_ok   = udr_p & (~full | pop);
    assign drop      = udr_p & full & ~pop;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
    end

    // Storage is cleared on reset so the head reads zero and nothing stale survives a flush.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {ir_q, sr};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    assign head   = mem_q[rd_ptr_q];
    assign cmd_ch = head[ENT_W-1 -: IR_W];
    assign jdo    = head[DATA_W-1:0];

    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_valid && cmd_ch == IR_W'(i)) begin
                take_action[i]    = jdo[ACT_BIT];
                take_no_action[i] = ~jdo[ACT_BIT];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)     ovf_q <= 1'b0;
        else if (ovf_clr) ovf_q <= 1'b0;
        else if (drop)    ovf_q <= 1'b1;
    end
    assign ovf = ovf_q;

`ifdef DBG_BRIDGE_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;
    always_ff @(posedge clk) begin
        if (!reset_n)                      ovf_cnt_q <= '0;
        else if (ovf_clr)                  ovf_cnt_q <= '0;
        else if (drop && ovf_cnt_q != '1)  ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end
    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_doodlejump_soc_debug_cmd_bridge.sv
// Bench for the debug command bridge: table vectors plus scoreboard-checked hand sequences.
module tb_doodlejump_soc_debug_cmd_bridge;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_uir, vs_udr, cmd_ready, ovf_clr;
    logic        cmd_valid;
    logic [1:0]  cmd_ch;
    logic [37:0] jdo;
    logic [3:0]  take_action, take_no_action;
    logic        ovf;
    logic [7:0]  ovf_cnt;

    int tests = 0;
    int fails = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [1:0]  ch;
        logic [37:0] sr;
        logic [3:0]  act;
        logic [3:0]  noact;
    } cmd_t;

    cmd_t sb[$];
    cmd_t vec[5];
    cmd_t e;

    doodlejump_soc_debug_cmd_bridge dut (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
        .vs_uir(vs_uir), .vs_udr(vs_udr), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
        .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .jdo(jdo),
        .take_action(take_action), .take_no_action(take_no_action),
        .ovf(ovf), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [1:0] ch, input logic [37:0] d);
        cmd_t c;
        c.ch = ch; c.sr = d; c.act = '0; c.noact = '0;
        if (d[35]) c.act[ch] = 1'b1;
        else       c.noact[ch] = 1'b1;
        return c;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic uir_pulse(input logic [1:0] ch);
        ir_in = ch; vs_uir = 1'b1; cyc(3);
        vs_uir = 1'b0; cyc(3);
    endtask

    task automatic udr_pulse(input logic [37:0] d);
        sr = d; vs_udr = 1'b1; cyc(3);
        vs_udr = 1'b0; cyc(3);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_valid"}, cmd_valid, 0);
        check({tag, "_ch"}, cmd_ch, 0);
        check({tag, "_jdo"}, jdo, 0);
        check({tag, "_act"}, take_action, 0);
        check({tag, "_noact"}, take_no_action, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_ovfcnt"}, ovf_cnt, 0);
    endtask

    // Every accepted pop is matched against the oldest expected command.
    always @(negedge clk) begin
        if (mon_en && reset_n && cmd_valid && cmd_ready) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb_unexpected: got ch %0d jdo %h, expected no command", cmd_ch, jdo);
            end else begin
                e = sb.pop_front();
                check("sb_ch", cmd_ch, e.ch);
                check("sb_jdo", jdo, e.sr);
                check("sb_act", take_action, e.act);
                check("sb_noact", take_no_action, e.noact);
            end
        end
    end

    initial begin
        logic [0:0] lat_exp [5];
        vec[0] = '{2'd1, 38'h00_0000_5678, 4'b0000, 4'b0010};
        vec[1] = '{2'd3, 38'h08_DEAD_BEEF, 4'b1000, 4'b0000};
        vec[2] = '{2'd0, 38'h37_FFFF_FFFF, 4'b0000, 4'b0001};
        vec[3] = '{2'd2, 38'h3F_0000_0001, 4'b0100, 4'b0000};
        vec[4] = '{2'd2, 38'h00_0000_0000, 4'b0000, 4'b0100};
        lat_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        reset_n = 1'b0; ir_in = '0; sr = '0; vs_uir = 0; vs_udr = 0; cmd_ready = 0; ovf_clr = 0;
        cyc(3);
        check_reset_outs("rst");
        reset_n = 1'b1; cyc(2);
        mon_en = 1'b1;

        // First command: latency from the sampling edge to a visible command.
        cmd_ready = 1'b1;
        uir_pulse(2'd2);
        sb.push_back(mk(2'd2, 38'h08_0000_1234));
        sr = 38'h08_0000_1234; vs_udr = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("lat_valid_%0d", k), cmd_valid, lat_exp[k]);
        end
        #1 vs_udr = 1'b0; cyc(4);

        // Table vectors through the scoreboard.
        for (int i = 0; i < 5; i++) begin
            uir_pulse(vec[i].ch);
            sb.push_back(vec[i]);
            udr_pulse(vec[i].sr);
            cyc(2);
        end
        check("tbl_drained", sb.size(), 0);

        // Overflow: five strobes into a four-deep FIFO with the consumer stalled.
        cmd_ready = 1'b0;
        uir_pulse(2'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb.push_back(mk(2'd1, 38'h08_0000_0100 + 38'(i)));
            udr_pulse(38'h08_0000_0100 + 38'(i));
        end
        check("ovf_set", ovf, 1);
`ifdef DBG_BRIDGE_OVF_CNT_EN
        check("ovf_cnt_1", ovf_cnt, 1);
`else
        check("ovf_cnt_off", ovf_cnt, 0);
`endif
        cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("drain_valid_%0d", k), cmd_valid, 1);
        end
        @(negedge clk);
        check("drain_empty", cmd_valid, 0);
        cyc(1);
        ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
        check("ovf_clr", ovf, 0);
        check("ovf_clr_cnt", ovf_cnt, 0);

        // Full FIFO, push aligned with a pop: accepted, occupancy stays at four.
        cmd_ready = 1'b0;
        uir_pulse(2'd3);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(2'd3, 38'h00_0000_0200 + 38'(i)));
            udr_pulse(38'h00_0000_0200 + 38'(i));
        end
        sb.push_back(mk(2'd3, 38'h08_0000_0AAA));
        sr = 38'h08_0000_0AAA; vs_udr = 1'b1;
        cyc(2);
        cmd_ready = 1'b1;
        cyc(1);
        cmd_ready = 1'b0;
        check("align_ovf", ovf, 0);
        check("align_valid", cmd_valid, 1);
        cyc(2); vs_udr = 1'b0; cyc(3);
        udr_pulse(38'h00_0000_0BAD);
        check("align_full_drop", ovf, 1);
        cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("align_drain_%0d", k), cmd_valid, 1);
        end
        @(negedge clk);
        check("align_empty", cmd_valid, 0);
        cyc(1);
        ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;

        // Reset with queued commands flushes everything, including ir_q.
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) udr_pulse(38'h08_0000_0300 + 38'(i));
        check("pre_rst_valid", cmd_valid, 1);
        reset_n = 1'b0; cyc(1); reset_n = 1'b1;
        check_reset_outs("flush");
        cyc(8);
        check("flush_stays_empty", cmd_valid, 0);
        cmd_ready = 1'b1;
        sb.push_back(mk(2'd0, 38'h08_0000_0400));
        udr_pulse(38'h08_0000_0400);
        // A strobe held high through reset release is taken as a fresh edge.
        sb.push_back(mk(2'd0, 38'h00_0000_0500));
        sr = 38'h00_0000_0500; vs_udr = 1'b1;
        reset_n = 1'b0; cyc(2); reset_n = 1'b1;
        cyc(5); vs_udr = 1'b0; cyc(3);
        check("rst_edge_drained", sb.size(), 0);

        // Drop-counter saturation, then a clear coinciding with a drop.
        cmd_ready = 1'b0;
        for (int i = 0; i < 304; i++) udr_pulse(38'(i));
        check("sat_ovf", ovf, 1);
`ifdef DBG_BRIDGE_OVF_CNT_EN
        check("sat_cnt", ovf_cnt, 255);
`else
        check("sat_cnt_off", ovf_cnt, 0);
`endif
        ovf_clr = 1'b1;
        udr_pulse(38'h00_0000_0777);
        ovf_clr = 1'b0;
        check("clr_prio_ovf", ovf, 0);
        check("clr_prio_cnt", ovf_cnt, 0);
        check("sat_valid", cmd_valid, 1);
        reset_n = 1'b0; cyc(1); reset_n = 1'b1; cyc(2);

        check("sb_final_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
